// File: rtl/mem_bus_pkg.sv
// Types and constants shared by the SRAM port arbiter and its winner-select logic.
package mem_bus_pkg;

    localparam int MID_WIDTH = 1;

    typedef logic [MID_WIDTH-1:0] mid_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // With only two masters, the other master is the bitwise complement of the id.
    function automatic mid_t other_master(input mid_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way winner selection.
// Supports round-robin (based on the last grant) or fixed priority favouring master 0.
module rr_arbiter2
    import mem_bus_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  mid_t       last_grant,
    output logic       any_req,
    output mid_t       winner
);

    always_comb begin
        any_req = |req;
        winner  = '0;
        unique case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = (FIXED_PRIO != 0) ? mid_t'(1'b0) : other_master(last_grant);
            default: winner = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between two valid/ready masters.
// Each access is IDLE -> ACCESS -> RESP, which covers the SRAM's one-cycle read latency.
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [3:0]            mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  grant_id,
    output logic                  busy
);

    state_t state, state_next;

    mid_t grant_q;
    mid_t last_grant;
    mid_t winner;
    logic any_req;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .req        ({m1_valid, m0_valid}),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The request is captured only when leaving IDLE.
    // Later changes on the master's inputs therefore cannot disturb an access in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            grant_q <= '0;
        end else if (state == ST_IDLE && any_req) begin
            addr_q  <= winner[0] ? m1_addr  : m0_addr;
            wdata_q <= winner[0] ? m1_wdata : m0_wdata;
            wstrb_q <= winner[0] ? m1_wstrb : m0_wstrb;
            grant_q <= winner;
        end
    end

    // Starts at 1 so that master 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (state == ST_RESP) begin
            last_grant <= grant_q;
        end
    end

    always_comb begin
        state_next = state;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_wen    = '0;
        m0_ready   = 1'b0;
        m1_ready   = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        grant_id   = grant_q[0];
        busy       = (state != ST_IDLE);

        unique case (state)
            ST_IDLE: begin
                if (any_req) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_wen    = wstrb_q;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (grant_q[0]) begin
                    m1_ready = 1'b1;
                    m1_rdata = mem_rdata;
                end else begin
                    m0_ready = 1'b1;
                    m0_rdata = mem_rdata;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// A round-robin instance and a fixed-priority instance share the same stimulus.
// Each instance has its own behavioural SRAM.
module tb_mem_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [3:0]    m0_wstrb, m1_wstrb;

    logic          a_m0_ready, a_m1_ready, a_grant_id, a_busy;
    logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
    logic [AW-1:0] a_mem_addr;
    logic [3:0]    a_mem_wen;

    logic          b_m0_ready, b_m1_ready, b_grant_id, b_busy;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0] b_mem_addr;
    logic [3:0]    b_mem_wen;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(a_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(a_m1_rdata),
        .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .grant_id(a_grant_id), .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(b_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(b_m1_rdata),
        .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .grant_id(b_grant_id), .busy(b_busy)
    );

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];

    // Registered-read SRAM models: rdata returns the old word one cycle after the address.
    always @(posedge clk) begin
        a_mem_rdata <= mem_a[a_mem_addr[7:0]];
        b_mem_rdata <= mem_b[b_mem_addr[7:0]];
        for (int k = 0; k < 4; k++) begin
            if (a_mem_wen[k]) mem_a[a_mem_addr[7:0]][8*k +: 8] = a_mem_wdata[8*k +: 8];
            if (b_mem_wen[k]) mem_b[b_mem_addr[7:0]][8*k +: 8] = b_mem_wdata[8*k +: 8];
        end
    end

    typedef struct {
        bit          master;
        bit          is_read;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          master;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion of the round-robin instance pops one expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn === 1'b1) begin
            if (a_m0_ready || a_m1_ready) begin
                checkOutput("single_ready", 32'(a_m0_ready & a_m1_ready), 32'd0);
                checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("ready_master", 32'(a_m1_ready), 32'(e.master));
                    if (e.is_read)
                        checkOutput("rdata", e.master ? a_m1_rdata : a_m0_rdata, e.rdata);
                    checkOutput("other_rdata_zero", e.master ? a_m0_rdata : a_m1_rdata, 32'd0);
                end
            end
            if (a_mem_wen != 4'd0) checkOutput("wen_only_when_busy", 32'(a_busy), 32'd1);
        end
    end

    task automatic applyStimulus(input bit master, input logic [AW-1:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic [31:0] exp_rdata);
        int         lat;
        int         wen_pulses;
        logic [3:0] wen_seen;
        exp_t       e;
        @(negedge clk);
        if (master) begin
            m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end else begin
            m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end
        e.master = master; e.is_read = (wstrb == 4'd0); e.rdata = exp_rdata;
        sb.push_back(e);
        lat = 0; wen_pulses = 0; wen_seen = 4'd0;
        do begin
            @(negedge clk);
            lat++;
            if (a_mem_wen != 4'd0) begin
                wen_pulses++;
                wen_seen = a_mem_wen;
            end
        end while (!(master ? a_m1_ready : a_m0_ready) && lat < 10);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        checkOutput("latency", 32'(lat), 32'd2);
        checkOutput("wen_pulses", 32'(wen_pulses), (wstrb != 4'd0) ? 32'd1 : 32'd0);
        if (wstrb != 4'd0) checkOutput("wen_value", 32'(wen_seen), 32'(wstrb));
    endtask

    initial begin
        int   cyc, a_cnt, b0_cnt, b1_cnt, busy_cnt, rdy_cnt;
        exp_t e;

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[8'h10] = 32'hDEADBEEF; mem_b[8'h10] = 32'hDEADBEEF;
        mem_a[8'h20] = 32'hAAAAAAAA; mem_b[8'h20] = 32'hAAAAAAAA;
        mem_a[8'h05] = 32'h55AA55AA; mem_b[8'h05] = 32'h55AA55AA;
        mem_a[8'h40] = 32'h01020304; mem_b[8'h40] = 32'h01020304;

        vecs[0] = '{1'b0, 22'h10, 32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 22'h20, 32'h11223344, 4'b0010, 32'h0};
        vecs[2] = '{1'b0, 22'h20, 32'h0,        4'b0000, 32'hAAAA33AA};
        vecs[3] = '{1'b1, 22'h10, 32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 22'h30, 32'hCAFEF00D, 4'b1111, 32'h0};
        vecs[5] = '{1'b1, 22'h30, 32'h0,        4'b0000, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 22'h31, 32'h12345678, 4'b1001, 32'h0};
        vecs[7] = '{1'b1, 22'h31, 32'h0,        4'b0000, 32'h12000078};

        resetn = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        #1;
        checkOutput("rst_ready", 32'({a_m0_ready, a_m1_ready}), 32'd0);
        checkOutput("rst_rdata", a_m0_rdata | a_m1_rdata, 32'd0);
        checkOutput("rst_mem_wen", 32'(a_mem_wen), 32'd0);
        checkOutput("rst_mem_addr", 32'(a_mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", a_mem_wdata, 32'd0);
        checkOutput("rst_busy_grant", 32'({a_busy, a_grant_id}), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i])
            applyStimulus(vecs[i].master, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rdata);

        // Both masters held: round-robin alternates, fixed priority always picks master 0.
        @(negedge clk);
        e = '{1'b0, 1'b1, 32'hDEADBEEF}; sb.push_back(e);
        e = '{1'b1, 1'b1, 32'hCAFEF00D}; sb.push_back(e);
        e = '{1'b0, 1'b1, 32'hDEADBEEF}; sb.push_back(e);
        e = '{1'b1, 1'b1, 32'hCAFEF00D}; sb.push_back(e);
        m0_valid = 1'b1; m0_addr = 22'h10; m0_wstrb = 4'd0;
        m1_valid = 1'b1; m1_addr = 22'h30; m1_wstrb = 4'd0;
        cyc = 0; a_cnt = 0; b0_cnt = 0; b1_cnt = 0;
        while (a_cnt < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (a_m0_ready || a_m1_ready) begin
                checkOutput("rr_ready_cycle", 32'(cyc), 32'(2 + 3 * a_cnt));
                a_cnt++;
            end
            if (b_m0_ready) b0_cnt++;
            if (b_m1_ready) b1_cnt++;
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        checkOutput("rr_access_count", 32'(a_cnt), 32'd4);
        checkOutput("fp_m0_grants", 32'(b0_cnt), 32'd4);
        checkOutput("fp_m1_grants", 32'(b1_cnt), 32'd0);

        // Async reset during the ACCESS cycle of a write.
        @(negedge clk);
        m1_valid = 1'b1; m1_addr = 22'h40; m1_wdata = 32'hFFFFFFFF; m1_wstrb = 4'b1111;
        @(posedge clk);
        #1;
        checkOutput("rst_pre_wen", 32'(a_mem_wen), 32'hF);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("arst_wen", 32'(a_mem_wen), 32'd0);
        checkOutput("arst_busy", 32'(a_busy), 32'd0);
        checkOutput("arst_ready", 32'({a_m0_ready, a_m1_ready}), 32'd0);
        m1_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b0, 22'h10, 32'h0, 4'b0000, 32'hDEADBEEF);

        // Valid dropped and address changed after sampling: one access, original address.
        @(negedge clk);
        m0_valid = 1'b1; m0_addr = 22'h05; m0_wstrb = 4'd0;
        e = '{1'b0, 1'b1, 32'h55AA55AA}; sb.push_back(e);
        @(negedge clk);
        m0_valid = 1'b0;
        m0_addr = 22'h10;
        busy_cnt = 32'(a_busy);
        rdy_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            busy_cnt += 32'(a_busy);
            rdy_cnt  += 32'(a_m0_ready);
        end
        checkOutput("drop_ready_count", 32'(rdy_cnt), 32'd1);
        checkOutput("drop_busy_cycles", 32'(busy_cnt), 32'd2);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-master arbiter sharing the single SRAM port (mem_mem) between master 0 (the MPU's memory-side interface) and master 1 (a secondary requester, e.g. a DMA or boot/config loader).
- Both masters use the valid/ready handshake that picorv32 already speaks.
- The block serialises accesses, applies round-robin or fixed priority, and sequences the SRAM's one-cycle read latency.

Parameters:
- ADDR_WIDTH, 22, word-address width on the master and memory sides.
- DATA_WIDTH, 32, data width.
- FIXED_PRIO, 0: 0 = round-robin; 1 = master 0 always wins ties.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- m0_valid  in  1  master 0 request; held until m0_ready.
- m0_ready  out  1  master 0 completion, one-cycle pulse.
- m0_addr  in  ADDR_WIDTH  master 0 word address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_wstrb  in  4  master 0 byte strobes; 0 = read.
- m0_rdata  out  DATA_WIDTH  master 0 read data, valid while m0_ready=1.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  same as the m0_* ports, for master 1.
- mem_wen  out  4  SRAM byte write enables.
- mem_addr  out  ADDR_WIDTH  SRAM word address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_rdata  in  DATA_WIDTH  SRAM read data, registered by the SRAM one cycle after the address.
- grant_id  out  1  master currently owning the port; meaningful while busy=1.
- busy  out  1  access in progress (state != IDLE).

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=1, so master 0 wins the first tie.
- FSM, registered, three states:
  - IDLE: on a clk edge with any valid, pick the winner, latch its addr/wdata/wstrb into internal registers, set grant_id, go to ACCESS. With no valid, stay in IDLE.
  - ACCESS (1 cycle): drive mem_addr and mem_wdata from the latched values; mem_wen = latched wstrb. Go to RESP.
  - RESP (1 cycle): mem_wen=0. Assert m{grant_id}_ready=1 combinationally from state. m{grant_id}_rdata = mem_rdata, valid for reads and don't-care for writes. Update last_grant=grant_id. Go to IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: FIXED_PRIO=1 gives master 0; FIXED_PRIO=0 gives the master that is not last_grant.
- Latency and throughput:
  - Valid sampled at edge n gives ready high in cycle n+2.
  - Three cycles per access; no back-to-back overlap.
- Non-granted master's ready stays 0; its rdata is driven to 0.
- mem_wen is never nonzero outside ACCESS. Exactly one write pulse per write request.
- mem_addr and mem_wdata hold their last value in IDLE and RESP.
- Protocol violations:
  - If a master drops valid mid-access, the access still completes and ready still pulses.
  - A master changing addr/wdata mid-access has no effect, because the request was latched in IDLE.
- Starvation: under round-robin with both masters continuously valid, grants alternate 0,1,0,1.
- Reset mid-access: return to IDLE immediately; mem_wen=0 and ready=0 at once. A partial write may not complete. The aborted request is dropped and is not replayed.
- A request asserted in the RESP cycle is not sampled until the following IDLE edge.

Decomposition:
- Shared package mem_bus_pkg: state encoding (ST_IDLE, ST_ACCESS, ST_RESP) and the master-id width constant.
- Natural sub-module: rr_arbiter2. It is combinational winner selection from {m1_valid, m0_valid}, last_grant and FIXED_PRIO.
- The FSM and request latches stay in the top module.

Test Plan:
- Single read: preload mem[0x10]=0xDEADBEEF; m0 read at addr 0x10 -> m0_ready high 2 cycles after sampling, m0_rdata=0xDEADBEEF, m1_ready stays 0.
- Byte write: m1 write addr 0x20, wdata 0x11223344, wstrb 4'b0010, over old 0xAAAAAAAA -> mem_wen=0010 for exactly 1 cycle; readback 0xAAAA33AA.
- Simultaneous requests, FIXED_PRIO=0, both held for 4 accesses -> grant order 0,1,0,1; each access takes 3 cycles.
- Simultaneous requests, FIXED_PRIO=1, both held -> master 0 is granted every access and master 1 is never granted.
- Async reset: assert resetn=0 in the ACCESS cycle of a write -> mem_wen=0, busy=0 and both ready=0 with no clock edge. After release, the next request is served normally.
- Valid dropped after sampling: m0 read addr 0x05, valid low one cycle later -> m0_ready still pulses once, and there is no second access.
